// File: rtl/rep_add_pkg.sv
// rep_add_pkg
// Shared definitions for the repeated-addition multiplier: FSM state
// encoding and the default operand width.
// Optional feature macro used by this slice: REP_ADD_OPSWAP_EN.
package rep_add_pkg;

  localparam int REP_ADD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rep_add_datapath.sv
// rep_add_datapath
// Operand, repeat-count and product registers with the accumulate adder,
// the count decrementer and the count==0 / count==1 flags.
// Ports:
//   clk, rst      clock, async active-high reset
//   i_load        capture operands and clear the product
//   i_accum       product += A, B -= 1
//   i_a, i_b      operands from the top-level inputs
//   o_product     product register
//   o_b_zero      repeat count is zero
//   o_b_one       repeat count is one (last accumulate)
// Macro REP_ADD_OPSWAP_EN: capture the larger operand as the addend so
// the repeat count becomes min(a, b).
module rep_add_datapath #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_accum,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [PWIDTH-1:0] o_product,
  output logic              o_b_zero,
  output logic              o_b_one
);

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PWIDTH-1:0] r_product;
  logic [WIDTH-1:0]  w_a_cap;
  logic [WIDTH-1:0]  w_b_cap;
  logic [PWIDTH-1:0] w_a_ext;
  logic [PWIDTH-1:0] w_sum;
  logic [WIDTH-1:0]  w_b_dec;

`ifdef REP_ADD_OPSWAP_EN
  logic w_swap;
  assign w_swap  = (i_b > i_a);
  assign w_a_cap = w_swap ? i_b : i_a;
  assign w_b_cap = w_swap ? i_a : i_b;
`else
  assign w_a_cap = i_a;
  assign w_b_cap = i_b;
`endif

  assign w_a_ext = {{(PWIDTH-WIDTH){1'b0}}, r_a};
  assign w_sum   = r_product + w_a_ext;
  assign w_b_dec = r_b - {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else if (i_load) begin
      r_a       <= w_a_cap;
      r_b       <= w_b_cap;
      r_product <= '0;
    end else if (i_accum) begin
      r_product <= w_sum;
      r_b       <= w_b_dec;
    end
  end

  assign o_product = r_product;
  assign o_b_zero  = (r_b == '0);
  assign o_b_one   = (r_b == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rep_add_multiplier.sv
// rep_add_multiplier
// Unsigned multiplier by repeated addition: product = a_in added b_in times.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           request; only sampled in IDLE
//   a_in, b_in      operands, captured on an accepted start
//   busy            high in LOAD and ACCUM
//   done            one-cycle pulse in DONE
//   product         result, held until the next accepted start
// Macro REP_ADD_OPSWAP_EN: repeat count becomes min(a_in, b_in).
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for start
// ST_LOAD  | operands captured, test for zero repeat count
// ST_ACCUM | product += A once per cycle, count down B
// ST_DONE  | result valid, done pulse
module rep_add_multiplier
  import rep_add_pkg::*;
#(
  parameter int WIDTH  = REP_ADD_WIDTH,
  parameter int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              busy,
  output logic              done,
  output logic [PWIDTH-1:0] product
);

  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_accum;
  logic   w_b_zero;
  logic   w_b_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  w_next = w_b_zero ? ST_DONE : ST_ACCUM;
      // B==1 means this edge performs the final addition.
      ST_ACCUM: if (w_b_one) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load  = (r_state == ST_IDLE) && start;
    w_accum = (r_state == ST_ACCUM);
    busy    = (r_state == ST_LOAD) || (r_state == ST_ACCUM);
    done    = (r_state == ST_DONE);
  end

  rep_add_datapath #(
    .WIDTH  (WIDTH),
    .PWIDTH (PWIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_accum   (w_accum),
    .i_a       (a_in),
    .i_b       (b_in),
    .o_product (product),
    .o_b_zero  (w_b_zero),
    .o_b_one   (w_b_one)
  );

endmodule

// File: tb/tb_rep_add_multiplier.sv
`timescale 1ns/100ps
module tb_rep_add_multiplier;

  localparam int W  = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  typedef struct {
    logic [PW-1:0] prod;
    int            done_cyc;
    int            busy_n;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;

  rep_add_multiplier #(.WIDTH(W), .PWIDTH(PW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; a start accepted at edge k
  // is followed by done visible while cyc == k + N + 1 (k + 1 for b=0).
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: on every done pulse pop the oldest expectation and compare.
  always @(negedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(cyc), 64'(-1));
        end else begin
          e = sb.pop_front();
          chk({e.name, "_product"}, 64'(product), 64'(e.prod));
          chk({e.name, "_done_cyc"}, 64'(cyc), 64'(e.done_cyc));
          chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy_n));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW-1:0] p, input int off, input int bn,
                       input string nm, input bit push);
    exp_t e;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.prod = p; e.done_cyc = cyc + off; e.busy_n = bn; e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t e;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'd7, 16'd5, 32'd35, 6, 6, "mul_7x5", 1'b1);
    drain(30);
    issue(16'd123, 16'd0, 32'd0, 1, 1, "b_zero", 1'b1);
    drain(30);
    issue(16'd1, 16'd1, 32'd1, 2, 2, "b_one", 1'b1);
    drain(30);
    issue(16'hFFFF, 16'd3, 32'h0002_FFFD, 4, 4, "max_a", 1'b1);
    drain(30);
`ifdef REP_ADD_OPSWAP_EN
    issue(16'd3, 16'hFFFF, 32'h0002_FFFD, 4, 4, "swap_max", 1'b1);
    drain(30);
    issue(16'd0, 16'd9, 32'd0, 1, 1, "swap_a_zero", 1'b1);
    drain(30);
    issue(16'd4, 16'd6, 32'd24, 5, 5, "repulse", 1'b1);
`else
    issue(16'd0, 16'd9, 32'd0, 10, 10, "a_zero", 1'b1);
    drain(30);
    issue(16'd4, 16'd6, 32'd24, 7, 7, "repulse", 1'b1);
`endif
    // start re-pulsed with different operands while in ACCUM
    @(negedge clk);
    @(negedge clk);
    a_in = 16'd9; b_in = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(30);
    repeat (15) @(negedge clk);
    chk("repulse_product_hold", 64'(product), 64'd24);

    // async reset pulse mid-ACCUM aborts the operation without done
    issue(16'd5, 16'd10, 32'd0, 0, 0, "abort", 1'b0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #0.5;
    chk("abort_product", 64'(product), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    #0.5 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("abort_idle_product", 64'(product), 64'd0);
`ifdef REP_ADD_OPSWAP_EN
    issue(16'd2, 16'd3, 32'd6, 3, 3, "after_abort", 1'b1);
`else
    issue(16'd2, 16'd3, 32'd6, 4, 4, "after_abort", 1'b1);
`endif
    drain(30);

    // start held high: accepted every 5 cycles
    @(negedge clk);
    a_in = 16'd3; b_in = 16'd2; start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      e.prod = 32'd6; e.done_cyc = k + 3 + 5 * i; e.busy_n = 3; e.name = "held";
      sb.push_back(e);
    end
    for (int i = 0; i < 40 && cyc < k + 11; i++) @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rep_add_multiplier.md
REP_ADD_MULTIPLIER -- requirements
Module: rep_add_multiplier

Interface
REQ-001: Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002: Parameter PWIDTH, default 2*WIDTH, product width in bits; fixed at 2*WIDTH.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, asynchronous and active-high.
REQ-005: start  input  1  request a multiplication; sampled only in IDLE.
REQ-006: a_in  input  WIDTH  multiplicand (unsigned); captured on an accepted start.
REQ-007: b_in  input  WIDTH  multiplier/repeat count (unsigned); captured on an accepted start.
REQ-008: busy  output  1  high in LOAD and ACCUM.
REQ-009: done  output  1  one-cycle pulse in DONE state.
REQ-010: product  output  PWIDTH  result register; holds its value until the next accepted start.

Function
REQ-011: FSM states IDLE, LOAD, ACCUM, DONE; encoding is defined in the shared package.
REQ-012: IDLE: start=1 at a clock edge -> capture A<=a_in, B<=b_in, clear product to 0, go to LOAD.
REQ-013: LOAD (1 cycle): B==0 -> DONE; otherwise -> ACCUM.
REQ-014: ACCUM: each cycle product<=product+A (zero-extended to PWIDTH), B<=B-1; when B==1 at that edge -> DONE, otherwise stay in ACCUM.
REQ-015: DONE (1 cycle): done=1, busy=0, -> IDLE unconditionally.
REQ-016: Latency: start accepted at edge k -> done high during cycle k+2 when b=0, during cycle k+N+2 when b=N>0.
REQ-017: start while busy or done is high is ignored; operands are not re-captured.
REQ-018: start held high continuously -> a new operation is accepted in the IDLE cycle following each DONE (back-to-back period N+3).
REQ-019: Product arithmetic never overflows: (2^WIDTH-1)^2 fits in PWIDTH.
REQ-020: a_in=0 with b_in>0 still runs N ACCUM cycles; product=0.
REQ-021: All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

Reset
REQ-022: rst=1 forces, asynchronously, state=IDLE, A=0, B=0, product=0, busy=0, done=0.
REQ-023: rst asserted mid-operation aborts it; no done pulse is generated; after release the block waits in IDLE for a new start.

Configuration
REQ-024: Macro REP_ADD_OPSWAP_EN defined: on capture, if b_in>a_in then A<=b_in and B<=a_in, so the repeat count is min(a_in,b_in); latency becomes min+2 (2 if either operand is 0).
REQ-025: Macro absent: no swap; operands are captured as in REQ-012 and latency follows REQ-016 exactly.

Structure
REQ-026: Package rep_add_pkg holds the state typedef (IDLE, LOAD, ACCUM, DONE) and the default WIDTH constant.
REQ-027: Sub-module rep_add_datapath holds the A, B and product registers, the adder, the decrementer and the B==0/B==1 flags; the FSM stays in rep_add_multiplier.

Verification
REQ-028: WIDTH=16, a=7, b=5, start pulsed at edge k -> done during cycle k+7, product=35, busy high for cycles k+1..k+6.
REQ-029: a=123, b=0 -> done at k+2, product=0, no ACCUM cycle; with REP_ADD_OPSWAP_EN, a=0, b=9 -> done at k+2, product=0.
REQ-030: a=16'hFFFF, b=3 -> product=32'h0002_FFFD; with REP_ADD_OPSWAP_EN, a=3, b=16'hFFFF -> same product, done at k+5.
REQ-031: a=4, b=6 started; start re-pulsed with a=9, b=9 during ACCUM -> product=24, operands unchanged, only one done pulse.
REQ-032: rst pulsed for 1 ns (asynchronous) during ACCUM of a=5, b=10 -> product=0 and state IDLE immediately; no done; a following start with a=2, b=3 -> product=6.
REQ-033: start held high with a=3, b=2 -> done pulses every 5 cycles, product=6 each time.
